aes_addroundkey_stream: RTL and testbench
=========================================

Name: aes_addroundkey_stream

Overview:
Parametrised, handshaked AddRoundKey stage for the AES datapath. It XORs either the incoming plaintext (on load) or the current round state with the supplied round key, and tracks the round index. Results go into a 2-entry output buffer so the stage can sit between the round-key generator and the SubBytes/ShiftRows/MixColumns logic with independent back-pressure. It generalises the fixed 4-column, ld_r-driven, single-register add-round-key to NB columns, NR rounds, and valid/ready flow control.

Parameters:
NB, 4, number of 32-bit state columns; block width W = 32*NB.
NR, 10, number of rounds per block (10/12/14 for AES-128/192/256).
RW, $clog2(NR+1), derived width of the round index; not overridden.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous active-low reset.
in_valid  in  1  input transfer request.
in_ready  out  1  stage can accept an input this cycle.
ld  in  1  qualifies the input transfer as the start of a new block: use text_in, not state_in.
text_in  in  W  plaintext; bits [W-1:W-32] are column 0, MSB byte is row 0.
state_in  in  W  round state from the round logic; same mapping as text_in.
rk  in  W  round key; same mapping as text_in.
out_valid  out  1  buffer head valid.
out_ready  in  1  downstream accepts the head.
state_out  out  W  XOR result at the buffer head.
round_out  out  RW  round index of the head (0 = initial key add).
last_out  out  1  head is round NR.
busy  out  1  FSM in RUN.
err  out  1  sticky: a round transfer (ld=0) was accepted while IDLE.

Behaviour:
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- in_ready = (buffer count < 2). It does not depend combinationally on out_ready.
- Data: result = (ld ? text_in : state_in) ^ rk, bitwise over W bits. No byte reordering.
- Latency: a transfer accepted at edge t appears at the head by edge t+1 if the buffer was empty. Otherwise it follows in order (FIFO).
- FSM states IDLE and RUN, with round counter rcnt (RW bits):
  - IDLE + transfer with ld=1: push round 0; rcnt<=1; go to RUN.
  - IDLE + transfer with ld=0: result discarded (not pushed); err<=1; stay IDLE.
  - RUN + transfer with ld=0: push round rcnt with last = (rcnt==NR). If rcnt==NR, go to IDLE and rcnt<=0; otherwise rcnt<=rcnt+1.
  - RUN + transfer with ld=1: abort the current block; push round 0; rcnt<=1; stay RUN. Entries already buffered are kept.
- busy = (state==RUN).
- Buffer: 2 entries of {state, round, last}.
  - Simultaneous push and pop with count 1: count stays 1, the new entry becomes head.
  - Push and pop with count 2 cannot happen, because in_ready=0.
  - Pop when empty is ignored.
- Head outputs are held stable while out_valid && !out_ready.
- Reset (asynchronous, any time including mid-block or with a full buffer):
  - state IDLE, rcnt 0, count 0;
  - out_valid 0, state_out 0, round_out 0, last_out 0, busy 0, err 0;
  - in_ready becomes 1 after reset deasserts.
- err clears only on reset.

Test Plan:
- FIPS-197 App. B round 0: NB=4, ld=1, text_in=3243f6a8885a308d313198a2e0370734, rk=2b7e151628aed2a6abf7158809cf4f3c -> next cycle out_valid=1, state_out=193de3bea0f4e22b9ac68d2ae9f84808, round_out=0, last_out=0, busy=1.
- Full block: ld transfer, then 10 ld=0 transfers with state_in=0 and rk=round index replicated, out_ready=1 -> rounds 0..10 emitted in order; last_out=1 only on round 10; busy drops the cycle after the round-10 accept.
- Back-pressure: out_ready=0, push 3 transfers -> in_ready=0 after 2 accepts; head holds round-0 value; raising out_ready drains the entries in order; third transfer accepted once count<2.
- Abort: ld=1 after round 4 -> next output round_out=0 with text_in^rk; following ld=0 gives round 1.
- Error: ld=0 transfer while IDLE -> nothing pushed, out_valid stays 0, err=1 and held until reset.
- Reset mid-block with 2 entries buffered: assert rst low asynchronously -> out_valid=0, busy=0, round_out=0 immediately; after release, ld restarts at round 0. Repeat with NB=8, NR=14 -> last_out on round 14, 256-bit XOR correct.

Source files
------------

// File: rtl/aes_addroundkey_stream.sv
// AddRoundKey stage: XORs plaintext (ld) or round state with the round key and tags each result with its round index.
// Latency: one cycle into an empty 2-entry output buffer; otherwise results leave in FIFO order.
// Backpressure: in_ready is driven only by the registered buffer count, so it never depends combinationally on out_ready.
module aes_addroundkey_stream #(
   parameter  int NB = 4,
   parameter  int NR = 10,
   localparam int RW = $clog2(NR + 1),
   localparam int W  = 32 * NB
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          ld,
   input  logic [W-1:0]  text_in,
   input  logic [W-1:0]  state_in,
   input  logic [W-1:0]  rk,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  state_out,
   output logic [RW-1:0] round_out,
   output logic          last_out,
   output logic          busy,
   output logic          err
);

   typedef enum logic {IDLE, RUN} state_e;

   state_e          state_q, state_d;
   logic [RW-1:0]   rcnt_q, rcnt_d;
   logic            err_q, err_d;

   // Two-slot buffer: head slot drives the outputs, tail slot holds the second entry.
   logic [1:0]      count_q, count_d;
   logic [W-1:0]    head_dat_q, head_dat_d, tail_dat_q, tail_dat_d;
   logic [RW-1:0]   head_rnd_q, head_rnd_d, tail_rnd_q, tail_rnd_d;
   logic            head_last_q, head_last_d, tail_last_q, tail_last_d;

   logic            xfer_in, xfer_out;
   logic            push;
   logic [W-1:0]    push_dat;
   logic [RW-1:0]   push_rnd;
   logic            push_last;

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign xfer_in   = in_valid && in_ready;
   assign xfer_out  = out_valid && out_ready;
   assign push_dat  = (ld ? text_in : state_in) ^ rk;

   assign state_out = head_dat_q;
   assign round_out = head_rnd_q;
   assign last_out  = head_last_q;
   assign busy      = (state_q == RUN);
   assign err       = err_q;

   // Round tracking FSM: decides whether an accepted transfer is pushed and with which round tag.
   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      err_d     = err_q;
      push      = 1'b0;
      push_rnd  = '0;
      push_last = 1'b0;
      if (xfer_in) begin
         if (ld) begin
            // New block, or abort of the running one: always restarts at round 0.
            push    = 1'b1;
            rcnt_d  = RW'(1);
            state_d = RUN;
         end else if (state_q == IDLE) begin
            // A round transfer without a block in flight has no meaning; drop it and flag.
            err_d = 1'b1;
         end else begin
            push      = 1'b1;
            push_rnd  = rcnt_q;
            push_last = (rcnt_q == RW'(NR));
            if (rcnt_q == RW'(NR)) begin
               state_d = IDLE;
               rcnt_d  = '0;
            end else begin
               rcnt_d = rcnt_q + RW'(1);
            end
         end
      end
   end

   // Buffer update: push/pop combinations over the two slots.
   always_comb begin
      count_d     = count_q;
      head_dat_d  = head_dat_q;
      head_rnd_d  = head_rnd_q;
      head_last_d = head_last_q;
      tail_dat_d  = tail_dat_q;
      tail_rnd_d  = tail_rnd_q;
      tail_last_d = tail_last_q;
      if (push && (xfer_out || count_q == 2'd0)) begin
         // Empty buffer, or count 1 with a simultaneous pop: new entry becomes head.
         head_dat_d  = push_dat;
         head_rnd_d  = push_rnd;
         head_last_d = push_last;
         count_d     = 2'd1;
      end else if (push) begin
         tail_dat_d  = push_dat;
         tail_rnd_d  = push_rnd;
         tail_last_d = push_last;
         count_d     = 2'd2;
      end else if (xfer_out) begin
         head_dat_d  = tail_dat_q;
         head_rnd_d  = tail_rnd_q;
         head_last_d = tail_last_q;
         count_d     = count_q - 2'd1;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rcnt_q      <= '0;
         err_q       <= 1'b0;
         count_q     <= 2'd0;
         head_dat_q  <= '0;
         head_rnd_q  <= '0;
         head_last_q <= 1'b0;
         tail_dat_q  <= '0;
         tail_rnd_q  <= '0;
         tail_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rcnt_q      <= rcnt_d;
         err_q       <= err_d;
         count_q     <= count_d;
         head_dat_q  <= head_dat_d;
         head_rnd_q  <= head_rnd_d;
         head_last_q <= head_last_d;
         tail_dat_q  <= tail_dat_d;
         tail_rnd_q  <= tail_rnd_d;
         tail_last_q <= tail_last_d;
      end
   end

endmodule

// File: tb/tb_aes_addroundkey_stream.sv
// Directed bench for the AddRoundKey stage: one 128-bit/10-round instance and one 256-bit/14-round instance.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Back-pressure is exercised by holding out_ready low on the 128-bit instance.
module tb_aes_addroundkey_stream;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // 128-bit instance
   logic         a_in_valid, a_in_ready, a_ld, a_out_valid, a_out_ready, a_last, a_busy, a_err;
   logic [127:0] a_text, a_state, a_rk, a_sout;
   logic [3:0]   a_round;

   // 256-bit instance
   logic         b_in_valid, b_in_ready, b_ld, b_out_valid, b_out_ready, b_last, b_busy, b_err;
   logic [255:0] b_text, b_state, b_rk, b_sout;
   logic [3:0]   b_round;

   int checks = 0;
   int errors = 0;
   logic [7:0] rb;

   aes_addroundkey_stream #(.NB(4), .NR(10)) u_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .ld(a_ld),
      .text_in(a_text), .state_in(a_state), .rk(a_rk),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .state_out(a_sout), .round_out(a_round), .last_out(a_last),
      .busy(a_busy), .err(a_err)
   );

   aes_addroundkey_stream #(.NB(8), .NR(14)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .ld(b_ld),
      .text_in(b_text), .state_in(b_state), .rk(b_rk),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .state_out(b_sout), .round_out(b_round), .last_out(b_last),
      .busy(b_busy), .err(b_err)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      a_in_valid = 0; a_ld = 0; a_out_ready = 0; a_text = '0; a_state = '0; a_rk = '0;
      b_in_valid = 0; b_ld = 0; b_out_ready = 0; b_text = '0; b_state = '0; b_rk = '0;

      // Reset state
      #12;
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_state_out", a_sout, 0);
      chk("rst_round_out", a_round, 0);
      chk("rst_last_out", a_last, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_err", a_err, 0);
      step();
      rst = 1;
      step();
      chk("rst_in_ready", a_in_ready, 1);

      // FIPS-197 Appendix B, initial AddRoundKey
      a_in_valid = 1; a_ld = 1;
      a_text = 128'h3243f6a8885a308d313198a2e0370734;
      a_rk   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      step();
      a_in_valid = 0;
      chk("fips_out_valid", a_out_valid, 1);
      chk("fips_state_out", a_sout, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      chk("fips_round", a_round, 0);
      chk("fips_last", a_last, 0);
      chk("fips_busy", a_busy, 1);
      a_out_ready = 1;
      step();
      a_out_ready = 0;
      chk("fips_drained", a_out_valid, 0);

      // Full block: state_in=0, rk = round byte replicated, so output equals rk
      a_out_ready = 1; a_in_valid = 1; a_text = '0; a_state = '0;
      for (int r = 0; r <= 10; r++) begin
         a_ld = (r == 0);
         rb = 8'(r);
         a_rk = {16{rb}};
         step();
         chk($sformatf("blk_valid_r%0d", r), a_out_valid, 1);
         chk($sformatf("blk_round_r%0d", r), a_round, r);
         chk($sformatf("blk_state_r%0d", r), a_sout, {16{rb}});
         chk($sformatf("blk_last_r%0d", r), a_last, (r == 10));
         chk($sformatf("blk_busy_r%0d", r), a_busy, (r != 10));
      end
      a_in_valid = 0;
      step();
      chk("blk_drained", a_out_valid, 0);

      // Back-pressure: three transfers against a stalled output
      a_out_ready = 0; a_in_valid = 1;
      a_ld = 1; a_text = {4{32'hffffffff}}; a_rk = 128'h0123456789abcdef0123456789abcdef;
      step();
      chk("bp_ready_after1", a_in_ready, 1);
      a_ld = 0; a_state = {4{32'haaaaaaaa}}; a_rk = {4{32'h55555555}};
      step();
      chk("bp_ready_after2", a_in_ready, 0);
      chk("bp_head_state", a_sout, 128'hfedcba9876543210fedcba9876543210);
      a_state = '0; a_rk = {4{32'hdeadbeef}};
      step();
      chk("bp_held_ready", a_in_ready, 0);
      chk("bp_held_state", a_sout, 128'hfedcba9876543210fedcba9876543210);
      chk("bp_held_round", a_round, 0);
      chk("bp_held_valid", a_out_valid, 1);
      a_out_ready = 1;
      step();
      chk("bp_pop1_state", a_sout, {4{32'hffffffff}});
      chk("bp_pop1_round", a_round, 1);
      chk("bp_pop1_ready", a_in_ready, 1);
      step();
      chk("bp_third_state", a_sout, {4{32'hdeadbeef}});
      chk("bp_third_round", a_round, 2);
      a_in_valid = 0;
      step();
      chk("bp_drained", a_out_valid, 0);

      // Abort: ld=1 after round 4 restarts the block at round 0
      a_in_valid = 1; a_state = '0; a_rk = '0; a_text = '0;
      for (int r = 0; r <= 4; r++) begin
         a_ld = (r == 0);
         step();
      end
      chk("ab_round4", a_round, 4);
      a_ld = 1; a_text = {4{32'h11111111}}; a_rk = {4{32'h22222222}};
      step();
      chk("ab_restart_round", a_round, 0);
      chk("ab_restart_state", a_sout, {4{32'h33333333}});
      chk("ab_restart_busy", a_busy, 1);
      a_ld = 0; a_state = '0; a_rk = '0;
      step();
      chk("ab_next_round", a_round, 1);
      chk("ab_next_state", a_sout, 0);
      a_in_valid = 0;
      step();
      chk("ab_no_err", a_err, 0);

      // Error: round transfer while IDLE
      rst = 0; #2; rst = 1;
      step();
      chk("er_idle_busy", a_busy, 0);
      a_in_valid = 1; a_ld = 0; a_state = {4{32'haaaaaaaa}}; a_rk = '0;
      step();
      a_in_valid = 0;
      chk("er_no_push", a_out_valid, 0);
      chk("er_flag", a_err, 1);
      chk("er_still_idle", a_busy, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("er_sticky", a_err, 1);

      // Asynchronous reset with both buffers full
      a_out_ready = 0; b_out_ready = 0;
      a_in_valid = 1; b_in_valid = 1; a_ld = 1; b_ld = 1;
      a_text = {4{32'h12345678}}; b_text = {8{32'h12345678}};
      step();
      a_ld = 0; b_ld = 0;
      step();
      a_in_valid = 0; b_in_valid = 0;
      chk("mr_a_full", a_in_ready, 0);
      chk("mr_b_full", b_in_ready, 0);
      #2 rst = 0;
      #1;
      chk("mr_a_valid", a_out_valid, 0);
      chk("mr_a_busy", a_busy, 0);
      chk("mr_a_round", a_round, 0);
      chk("mr_a_state", a_sout, 0);
      chk("mr_a_err", a_err, 0);
      chk("mr_b_valid", b_out_valid, 0);
      chk("mr_b_busy", b_busy, 0);
      #2 rst = 1;
      step();
      chk("mr_a_ready", a_in_ready, 1);
      a_in_valid = 1; a_ld = 1; a_text = {4{32'hffffffff}}; a_rk = '0;
      step();
      a_in_valid = 0;
      chk("mr_restart_round", a_round, 0);
      chk("mr_restart_state", a_sout, {4{32'hffffffff}});

      // 256-bit / 14-round full block
      b_out_ready = 1; b_in_valid = 1; b_state = '0;
      b_text = 256'h00112233445566778899aabbccddeeffffeeddccbbaa99887766554433221100;
      for (int r = 0; r <= 14; r++) begin
         b_ld = (r == 0);
         rb = 8'(r);
         b_rk = (r == 0) ? {32{8'h0f}} : {32{rb}};
         step();
         chk($sformatf("wb_round_r%0d", r), b_round, r);
         chk($sformatf("wb_last_r%0d", r), b_last, (r == 14));
         if (r == 0)
            chk("wb_state_r0", b_sout,
                256'h0f1e2d3c4b5a69788796a5b4c3d2e1f0f0e1d2c3b4a5968778695a4b3c2d1e0f);
         else
            chk($sformatf("wb_state_r%0d", r), b_sout, {32{rb}});
      end
      b_in_valid = 0;
      step();
      chk("wb_busy_done", b_busy, 0);
      chk("wb_drained", b_out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
